// File: rtl/cal_port_issuer.sv
// cal_port_issuer
// ---------------
// Request issuer for one calculator port. It accepts whole host operations
// through a valid/ready handshake and allocates the lowest free 2-bit tag.
// Each operation is sent as a two-beat request: {cmd, tag, op_a}, then
// {0, 0, op_b}. The block tracks the tags in flight and returns each matched
// calculator response to the host as a one-cycle strobe.
//
// Ports
//   clk, reset                 rising-edge clock, synchronous active-high reset
//   op_valid/op_ready          host operation handshake
//   op_cmd, op_a, op_b         operation command and operands
//   op_tag                     tag allocated to the op accepted this cycle
//   req_cmd/req_tag/req_data   registered request beats to the calculator
//   out_resp/out_tag/out_data  calculator response inputs
//   rsp_valid/rsp_tag/rsp_resp/rsp_data  registered response strobe to host
//   outstanding_cnt            number of tags in flight
//   err_spurious               sticky flag: response for a tag not in flight
module cal_port_issuer #(
    parameter int MAX_OUTSTANDING = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        op_valid,
    output logic        op_ready,
    input  logic [3:0]  op_cmd,
    input  logic [31:0] op_a,
    input  logic [31:0] op_b,
    output logic [1:0]  op_tag,
    output logic [3:0]  req_cmd,
    output logic [1:0]  req_tag,
    output logic [31:0] req_data,
    input  logic [1:0]  out_resp,
    input  logic [1:0]  out_tag,
    input  logic [31:0] out_data,
    output logic        rsp_valid,
    output logic [1:0]  rsp_tag,
    output logic [1:0]  rsp_resp,
    output logic [31:0] rsp_data,
    output logic [2:0]  outstanding_cnt,
    output logic        err_spurious
);

    typedef enum logic [1:0] {IDLE, OP1, OP2} state_t;

    // Only tags below MAX_OUTSTANDING may ever be allocated.
    localparam logic [3:0] TAG_MASK = 4'((1 << MAX_OUTSTANDING) - 1);

    function automatic logic [2:0] popcount4(input logic [3:0] v);
        return 3'(v[0]) + 3'(v[1]) + 3'(v[2]) + 3'(v[3]);
    endfunction

    state_t      state, state_d;
    logic [3:0]  busy, busy_d;
    logic [31:0] b_hold, b_hold_d;     // op_b held for the second beat
    logic [3:0]  req_cmd_d;
    logic [1:0]  req_tag_d;
    logic [31:0] req_data_d;

    logic [3:0]  free_mask;
    logic [1:0]  alloc_tag;
    logic        accept;
    logic        alloc_en;
    logic        rsp_hit;
    logic        rsp_stray;

    assign free_mask = ~busy & TAG_MASK;

    // Lowest-numbered free tag; scanning downward leaves the smallest index.
    always_comb begin
        alloc_tag = '0;
        for (int i = 3; i >= 0; i--) begin
            if (free_mask[i]) alloc_tag = 2'(i);
        end
    end

    assign op_ready  = !reset && (state != OP1) && (|free_mask);
    assign op_tag    = alloc_tag;
    assign accept    = op_valid && op_ready;
    // A no-op still takes the two request cycles but holds no tag.
    assign alloc_en  = accept && (op_cmd != 4'd0);
    assign rsp_hit   = (out_resp != 2'd0) && busy[out_tag];
    assign rsp_stray = (out_resp != 2'd0) && !busy[out_tag];

    // NOTE: every signal written here gets a default first, so no path can
    // leave one unassigned and infer a latch.
    always_comb begin
        state_d    = state;
        b_hold_d   = b_hold;
        req_cmd_d  = '0;
        req_tag_d  = '0;
        req_data_d = '0;
        busy_d     = busy;

        case (state)
            IDLE: if (accept) state_d = OP1;
            OP1: begin
                state_d    = OP2;
                req_data_d = b_hold;
            end
            OP2: state_d = accept ? OP1 : IDLE;
            default: state_d = IDLE;
        endcase

        // accept is never true in OP1, so this cannot clash with the OP2 beat.
        if (accept) begin
            req_cmd_d  = op_cmd;
            req_tag_d  = alloc_en ? alloc_tag : 2'd0;
            req_data_d = op_a;
            b_hold_d   = op_b;
        end

        // Retire and allocate touch different bits: alloc_tag comes from the
        // pre-edge mask, where the retiring tag is still marked busy.
        if (rsp_hit)  busy_d[out_tag]   = 1'b0;
        if (alloc_en) busy_d[alloc_tag] = 1'b1;
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values, independent of statement order.
    always_ff @(posedge clk) begin
        if (reset) begin
            state           <= IDLE;
            busy            <= '0;
            b_hold          <= '0;
            req_cmd         <= '0;
            req_tag         <= '0;
            req_data        <= '0;
            rsp_valid       <= 1'b0;
            rsp_tag         <= '0;
            rsp_resp        <= '0;
            rsp_data        <= '0;
            outstanding_cnt <= '0;
            err_spurious    <= 1'b0;
        end else begin
            state           <= state_d;
            busy            <= busy_d;
            b_hold          <= b_hold_d;
            req_cmd         <= req_cmd_d;
            req_tag         <= req_tag_d;
            req_data        <= req_data_d;
            rsp_valid       <= rsp_hit;
            rsp_tag         <= rsp_hit ? out_tag  : 2'd0;
            rsp_resp        <= rsp_hit ? out_resp : 2'd0;
            rsp_data        <= rsp_hit ? out_data : 32'd0;
            outstanding_cnt <= popcount4(busy_d);
            if (rsp_stray) err_spurious <= 1'b1;
        end
    end

endmodule

// File: tb/tb_cal_port_issuer.sv
// Testbench for cal_port_issuer. Expected request beats and host responses
// are queued when stimulus is applied and compared when the DUT drives them.
module tb_cal_port_issuer;

    logic        clk = 1'b0;
    logic        reset;
    logic        op_valid;
    logic        op_ready;
    logic [3:0]  op_cmd;
    logic [31:0] op_a, op_b;
    logic [1:0]  op_tag;
    logic [3:0]  req_cmd;
    logic [1:0]  req_tag;
    logic [31:0] req_data;
    logic [1:0]  out_resp, out_tag;
    logic [31:0] out_data;
    logic        rsp_valid;
    logic [1:0]  rsp_tag, rsp_resp;
    logic [31:0] rsp_data;
    logic [2:0]  outstanding_cnt;
    logic        err_spurious;

    always #5 clk = ~clk;

    cal_port_issuer #(.MAX_OUTSTANDING(4)) dut (
        .clk(clk), .reset(reset),
        .op_valid(op_valid), .op_ready(op_ready), .op_cmd(op_cmd),
        .op_a(op_a), .op_b(op_b), .op_tag(op_tag),
        .req_cmd(req_cmd), .req_tag(req_tag), .req_data(req_data),
        .out_resp(out_resp), .out_tag(out_tag), .out_data(out_data),
        .rsp_valid(rsp_valid), .rsp_tag(rsp_tag), .rsp_resp(rsp_resp),
        .rsp_data(rsp_data), .outstanding_cnt(outstanding_cnt),
        .err_spurious(err_spurious)
    );

    typedef struct packed {
        logic [3:0]  cmd;
        logic [1:0]  tag;
        logic [31:0] data;
    } beat_t;

    typedef struct packed {
        logic [1:0]  tag;
        logic [1:0]  resp;
        logic [31:0] data;
    } rsp_t;

    beat_t      req_q[$];
    rsp_t       rsp_q[$];
    logic [3:0] busy_m;
    logic       err_m;
    int         checks = 0;
    int         failures = 0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%0h expected=0x%0h at %0t", name, got, exp, $time);
        end
    endtask

    function automatic logic [1:0] lowest_free(input logic [3:0] b);
        logic [1:0] t = 2'd0;
        for (int i = 3; i >= 0; i--) if (!b[i]) t = 2'(i);
        return t;
    endfunction

    function automatic logic [2:0] count_ones(input logic [3:0] b);
        int n = 0;
        for (int i = 0; i < 4; i++) if (b[i]) n++;
        return 3'(n);
    endfunction

    task automatic set_op(input logic v, input logic [3:0] c, input logic [31:0] a, input logic [31:0] b);
        op_valid = v; op_cmd = c; op_a = a; op_b = b;
    endtask

    task automatic set_rsp(input logic [1:0] r, input logic [1:0] t, input logic [31:0] d);
        out_resp = r; out_tag = t; out_data = d;
    endtask

    // One clock cycle: check handshake outputs, let the edge happen, update
    // the reference state, then check registered outputs on the falling edge.
    task automatic step();
        logic       exp_ready, acc, hit, stray;
        logic [1:0] acc_tag;
        beat_t      eb;
        rsp_t       er;
        #1;
        exp_ready = !reset && (req_q.size() == 0) && (busy_m != 4'hF);
        check("op_ready", 32'(op_ready), 32'(exp_ready));
        acc     = op_valid && exp_ready;
        acc_tag = lowest_free(busy_m);
        if (acc && op_cmd != 4'd0) check("op_tag", 32'(op_tag), 32'(acc_tag));
        hit   = (out_resp != 2'd0) && busy_m[out_tag];
        stray = (out_resp != 2'd0) && !busy_m[out_tag];
        @(posedge clk);
        if (reset) begin
            req_q.delete();
            rsp_q.delete();
            busy_m = 4'h0;
            err_m  = 1'b0;
        end else begin
            if (hit) begin
                rsp_q.push_back('{tag: out_tag, resp: out_resp, data: out_data});
                busy_m[out_tag] = 1'b0;
            end
            if (stray) err_m = 1'b1;
            if (acc) begin
                req_q.push_back('{cmd: op_cmd, tag: (op_cmd != 4'd0) ? acc_tag : 2'd0, data: op_a});
                req_q.push_back('{cmd: 4'd0, tag: 2'd0, data: op_b});
                if (op_cmd != 4'd0) busy_m[acc_tag] = 1'b1;
            end
        end
        @(negedge clk);
        eb = (req_q.size() != 0) ? req_q.pop_front() : '0;
        check("req_cmd", 32'(req_cmd), 32'(eb.cmd));
        check("req_tag", 32'(req_tag), 32'(eb.tag));
        check("req_data", req_data, eb.data);
        if (rsp_q.size() != 0) begin
            er = rsp_q.pop_front();
            check("rsp_valid", 32'(rsp_valid), 32'd1);
            check("rsp_tag", 32'(rsp_tag), 32'(er.tag));
            check("rsp_resp", 32'(rsp_resp), 32'(er.resp));
            check("rsp_data", rsp_data, er.data);
        end else begin
            check("rsp_valid", 32'(rsp_valid), 32'd0);
        end
        check("outstanding_cnt", 32'(outstanding_cnt), 32'(count_ones(busy_m)));
        check("err_spurious", 32'(err_spurious), 32'(err_m));
    endtask

    task automatic idle(input int n);
        set_op(1'b0, 4'd0, 32'd0, 32'd0);
        set_rsp(2'd0, 2'd0, 32'd0);
        repeat (n) step();
    endtask

    initial begin
        busy_m = 4'h0;
        err_m  = 1'b0;
        reset  = 1'b1;
        set_op(1'b0, 4'd0, 32'd0, 32'd0);
        set_rsp(2'd0, 2'd0, 32'd0);
        repeat (2) step();
        reset = 1'b0;
        idle(1);

        // Single add: request beats, then response strobe.
        set_op(1'b1, 4'd1, 32'h0000_0003, 32'h0000_0004);
        step();
        idle(3);
        set_rsp(2'd1, 2'd0, 32'h0000_0007);
        step();
        idle(2);

        // Continuous op_valid fills all four tags, then stalls.
        for (int i = 0; i < 10; i++) begin
            set_op(1'b1, 4'd2, 32'h100 + 32'(i), 32'h200 + 32'(i));
            step();
        end
        // Response for tag 2 while full: no accept this cycle, tag 2 next.
        set_rsp(2'd1, 2'd2, 32'hAAAA_0002);
        step();
        set_rsp(2'd0, 2'd0, 32'd0);
        set_op(1'b1, 4'd5, 32'h300, 32'h400);
        step();
        idle(2);
        // Drain with different response codes.
        set_rsp(2'd2, 2'd0, 32'hBBBB_0000); step();
        set_rsp(2'd3, 2'd1, 32'hCCCC_0001); step();
        set_rsp(2'd1, 2'd2, 32'hDDDD_0002); step();
        set_rsp(2'd1, 2'd3, 32'hEEEE_0003); step();
        idle(2);

        // Spurious response: sticky flag, no strobe, until reset.
        set_rsp(2'd1, 2'd3, 32'h1234_5678);
        step();
        idle(3);
        reset = 1'b1; step();
        reset = 1'b0; idle(1);

        // No-op: two beats with cmd 0, no tag consumed.
        set_op(1'b1, 4'd0, 32'hA5A5_0001, 32'h5A5A_0002);
        step();
        idle(3);

        // Reset in the OP1 cycle with two tags busy.
        set_op(1'b1, 4'd1, 32'h11, 32'h22); step();
        set_op(1'b0, 4'd0, 32'd0, 32'd0);   step();
        set_op(1'b1, 4'd6, 32'h33, 32'h44); step();
        set_op(1'b0, 4'd0, 32'd0, 32'd0);
        reset = 1'b1; step();
        reset = 1'b0; idle(1);
        set_rsp(2'd1, 2'd0, 32'h99); step();
        idle(2);
        reset = 1'b1; step();
        reset = 1'b0; idle(1);

        // Random traffic against the reference model.
        for (int i = 0; i < 200; i++) begin
            set_op(1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), $urandom, $urandom);
            if ($urandom_range(0, 2) == 0)
                set_rsp(2'($urandom_range(1, 3)), 2'($urandom_range(0, 3)), $urandom);
            else
                set_rsp(2'd0, 2'd0, 32'd0);
            step();
        end
        idle(2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/cal_port_issuer.md
# cal_port_issuer

Per-port request issuer sitting directly upstream of one calculator port (req*_cmd_in / req*_tag_in / req*_data_in) and consuming that port's out_resp / out_tag / out_data. It accepts whole operations from a host through a valid/ready handshake and allocates a free 2-bit tag. It serialises each operation into the calculator's two-cycle request protocol, tracks outstanding tags, and returns each matched response to the host with its tag. One instance is used per calculator port.

## Interface
- MAX_OUTSTANDING, 4: tags that may be in flight at once (1..4); tags 0..MAX_OUTSTANDING-1 are used.
- clk  input  1  rising-edge clock for all state.
- reset  input  1  synchronous, active-high reset; one clock, no other clock domains.
- op_valid  input  1  host operation valid.
- op_ready  output  1  issuer can accept; an op transfers when op_valid && op_ready at a rising edge.
- op_cmd  input  [0:3]  calculator command (0 no-op, 1 add, 2 sub, 5 shl, 6 shr; others passed through).
- op_a, op_b  input  [0:31] each  operand 1 and operand 2.
- op_tag  output  [0:1]  tag allocated to the op accepted this cycle; valid only while op_valid && op_ready.
- req_cmd  output  [0:3]  to the calculator's cmd input.
- req_tag  output  [0:1]  to the calculator's tag input.
- req_data  output  [0:31]  to the calculator's data input.
- out_resp  input  [0:2-1]  from calculator: 0 none, 1 success, 2 overflow/underflow/invalid, 3 internal error.
- out_tag  input  [0:1]  from calculator.
- out_data  input  [0:31]  from calculator.
- rsp_valid  output  1  one-cycle response strobe to the host; no backpressure.
- rsp_tag, rsp_resp  output  [0:1] each; rsp_data  output  [0:31].
- outstanding_cnt  output  [0:2]  number of tags currently in flight (0..4).
- err_spurious  output  1  sticky: a response arrived for a tag that was not outstanding.

## Operation
- State machine: IDLE, OP1, OP2. All outputs are registered.
- IDLE→OP1 on accept. OP1→OP2 unconditionally. OP2→OP1 on accept in that cycle, else OP2→IDLE.
- op_ready = (state != OP1) && (a free tag exists). It is combinational from registered state only and does not depend on op_valid.
- OP1 cycle: req_cmd = op_cmd, req_tag = allocated tag, req_data = op_a.
- OP2 cycle: req_cmd = 0, req_tag = 0, req_data = op_b.
- IDLE: req_cmd = 0, req_tag = 0, req_data = 0.
- op_cmd == 0 is accepted: no tag is allocated, no busy bit is set, req_cmd = 0 in both cycles, and operands are still driven.
- Tag allocation picks the lowest-numbered free tag in the registered busy mask. The busy bit is set at the accept edge.
- Retirement:
  - A response is out_resp != 0 with busy[out_tag] == 1.
  - The edge clears busy[out_tag] and registers rsp_valid = 1, rsp_tag = out_tag, rsp_resp = out_resp, rsp_data = out_data.
- A response with busy[out_tag] == 0 sets err_spurious, emits no rsp_valid, and leaves busy unchanged.
- Same cycle retire and accept: allocation uses the pre-edge busy mask, so a tag retired this cycle is not reused until the next cycle. Both updates apply at the same edge.
- outstanding_cnt = popcount(busy); it updates at the same edge as busy.
- The busy mask is sized to 4 bits; tags at or above MAX_OUTSTANDING are never allocated.

## Timing
- Reset (synchronous; takes effect at the edge where reset = 1):
  - Outputs: req_* = 0, rsp_valid = 0, rsp_tag/rsp_resp/rsp_data = 0, outstanding_cnt = 0, err_spurious = 0.
  - State: IDLE, busy = 0.
  - op_ready is 0 while reset is asserted.
- Reset mid-operation aborts any OP1/OP2 sequence and discards all busy tags. Responses arriving later for pre-reset tags are spurious and set err_spurious.
- Accept at edge T:
  - Cycle after T: req_cmd/req_tag/req_data carry the OP1 values.
  - Next cycle: OP2 values.
  - Maximum throughput is one op per 2 cycles.
- A response present at edge R appears on rsp_* during cycle R+1, lasting exactly one cycle.
- Busy release is visible to op_ready in cycle R+1.

## Test plan
- Reset, then one op (cmd 1, a = 0x00000003, b = 0x00000004): op_tag = 0. Next cycle req = {1, 0, 0x00000003}, then {0, 0, 0x00000004}, outstanding_cnt = 1. Response {resp 1, tag 0, data 0x00000007} → rsp_valid one cycle with the same values; cnt = 0.
- Continuous op_valid: ops are accepted every 2 cycles with tags 0, 1, 2, 3. op_ready drops after the 4th and stays low until the first response; that response's tag is reallocated one cycle later.
- All 4 busy, response for tag 2 plus op_valid in the same cycle: no accept that cycle. The next cycle accepts with op_tag = 2.
- Response {resp 1, tag 3} with tag 3 not busy: err_spurious = 1 and stays set, no rsp_valid, cnt unchanged. Reset clears it.
- op_cmd = 0 accepted: req_cmd = 0 in both cycles, req_data = a then b, outstanding_cnt unchanged.
- Reset asserted during OP1 with 2 tags busy: next cycle req_* = 0 and cnt = 0. A later response on tag 0 sets err_spurious.
